seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Output-side board I/O: drives the 8-digit multiplexed 7-segment display (seg/an, active-low).
//  Scans one digit per prescaler tick and decodes a 4-bit hex nibble per digit.
//  Takes a tear-free update handshake from user logic, committed only at frame boundaries.
//  Sits between the lab's datapath and the top-level seg/an pins; complements the button input filters.
// PARAMETERS
//  PRESCALE  12500  CLK cycles per digit slot (100 MHz -> 8 kHz digit, 1 kHz frame); legal >= 2
//  N_DIG     8      digits scanned; fixed at 8 (matches an[7:0])
// PORTS
//  CLK         in   1   system clock, all logic rising-edge
//  RST_N       in   1   asynchronous active-low reset
//  load        in   1   1-cycle strobe: stage data_in/dp_in/en_in
//  data_in     in   32  hex nibbles, [3:0]=digit0 (rightmost) .. [31:28]=digit7
//  dp_in       in   8   decimal point per digit, 1=lit
//  en_in       in   8   digit enable, 0=digit blanked (anode off)
//  upd_ack     out  1   1-cycle pulse: staged values committed to display
//  frame_done  out  1   1-cycle pulse on digit 7->0 wrap
//  seg         out  8   {DP,G,F,E,D,C,B,A}, active-low
//  an          out  8   anode select, active-low, one-hot-low or all-ones
// BEHAVIOUR
//  Reset: cnt=0, idx=0, staged/shadow=0, pending=0; seg=8'hFF, an=8'hFF, upd_ack=0, frame_done=0.
//  Prescaler: cnt counts 0..PRESCALE-1; tick when cnt==PRESCALE-1; cnt wraps to 0.
//  Scan: idx increments on tick; wrap = tick & idx==7 -> idx=0, frame_done=1 next cycle.
//  Load: on load, staged<=inputs, pending<=1. Repeated loads before wrap: last one wins.
//  Commit: on wrap with pending=1 (value before this cycle), shadow<=staged(pre-load), upd_ack=1 next cycle.
//   pending_next = load | (pending & ~wrap). Load coincident with wrap commits the OLD staged
//   value now; the new value stays pending and commits at the following wrap.
//  Outputs registered, 1 cycle after idx/shadow change:
//   an  = shadow_en[idx] ? ~(8'b1 << idx) : 8'hFF
//   seg = {~shadow_dp[idx], hex2seg(shadow_data[4*idx+:4])}; if digit blanked, seg=8'hFF
//  hex2seg (active-low GFEDCBA): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//   A=08 b=03 C=46 d=21 E=06 F=0E.
//  At most one an bit low at any time; never glitch two anodes in same cycle.
//  Reset mid-frame: immediate async return to reset state; pending update discarded.
// CONFIGURATION
//  Macro SEG7_BRIGHTNESS_EN:
//   defined -> extra port brightness in 3 (0=dimmest, 7=full). Anode of current digit driven
//    low only while cnt < ((brightness+1)*PRESCALE)>>3 within the slot, else an=8'hFF;
//    brightness sampled each cycle (not part of load handshake); seg unaffected.
//   undefined -> no port; anode low for the full slot.
// STRUCTURE
//  Package seg7_pkg: N_DIG, SEG_BLANK=8'hFF, AN_OFF=8'hFF, hex2seg lookup function/constants.
//  Sub-module seg7_hex_decoder (combinational nibble -> 7 active-low segments); rest in this block.
// TESTING (sim with PRESCALE=4)
//  1 Reset: hold RST_N=0 -> seg=8'hFF, an=8'hFF, no pulses; release -> an=8'hFF until first commit.
//  2 load data_in=32'h76543210, en_in=FF, dp_in=01 -> upd_ack at first wrap; then an cycles
//    FE,FD,..,7F every 4 clk; digit0 seg=8'h40 (DP lit), digit1 seg=8'hF9.
//  3 en_in=8'h0F -> an=8'hFF, seg=8'hFF during slots 4..7; frame_done every 32 clk.
//  4 Load A then load B in same frame -> only B displayed, single upd_ack.
//  5 Load on exact wrap cycle -> old staged committed now, new value commits 32 clk later, 2 upd_acks.
//  6 SEG7_BRIGHTNESS_EN, brightness=1 -> an active 1 of 4 clk per slot; brightness=7 -> all 4.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and the hex -> active-low 7-segment lookup
// for the multiplexed display driver.
package seg7_pkg;

  localparam int          N_DIG     = 8;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [7:0]  AN_OFF    = 8'hFF;

  // Active-low {G,F,E,D,C,B,A}; a 0 bit lights the segment.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: user-side update handshake of the display driver.
// master = user logic staging new display contents, slave = the driver.
interface seg7_scan_driver_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_in;
  logic        upd_ack;
  logic        frame_done;

  modport master (output load, data_in, dp_in, en_in,
                  input  upd_ack, frame_done);
  modport slave  (input  load, data_in, dp_in, en_in,
                  output upd_ack, frame_done);
endinterface

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: combinational nibble -> active-low GFEDCBA segments.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  assign o_seg = hex2seg(i_nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed 7-segment scanner with a tear-free
// update path. New contents are staged on load and copied to the displayed
// (shadow) set only on the digit 7 -> 0 wrap, so a frame never mixes two
// updates.
// Optional feature macro: SEG7_BRIGHTNESS_EN (adds a 3-bit brightness port
// that shortens the anode-on window within each digit slot).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int PRESCALE = 12500
) (
  input  logic              CLK,
  input  logic              RST_N,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [2:0]        brightness,
`endif
  seg7_scan_driver_if.slave bus,
  output logic [7:0]        seg,
  output logic [7:0]        an
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_stg_data;
  logic [7:0]    r_stg_dp;
  logic [7:0]    r_stg_en;
  logic          r_pending;
  logic [31:0]   r_shd_data;
  logic [7:0]    r_shd_dp;
  logic [7:0]    r_shd_en;
  logic          r_upd_ack;
  logic          r_frame_done;
  logic [7:0]    r_seg;
  logic [7:0]    r_an;

  logic          w_tick;
  logic          w_wrap;
  logic [4:0]    w_base;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg7;
  logic          w_dig_en;
  logic          w_an_on;

  assign w_tick = (r_cnt == CW'(PRESCALE - 1));
  assign w_wrap = w_tick && (r_idx == 3'(N_DIG - 1));

  assign w_base   = {r_idx, 2'b00};
  assign w_nib    = r_shd_data[w_base +: 4];
  assign w_dig_en = r_shd_en[r_idx];

`ifdef SEG7_BRIGHTNESS_EN
  // Anode window scales with brightness: (b+1)/8 of the slot, from cnt 0.
  logic [31:0] w_thr;
  assign w_thr   = (({29'd0, brightness} + 32'd1) * 32'(PRESCALE)) >> 3;
  assign w_an_on = w_dig_en && ({{(32-CW){1'b0}}, r_cnt} < w_thr);
`else
  assign w_an_on = w_dig_en;
`endif

  seg7_hex_decoder u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_seg7)
  );

  // Prescaler and digit index; idx advances once per slot and wraps 7 -> 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Staging register: last load before a wrap wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stg_data <= '0;
      r_stg_dp   <= '0;
      r_stg_en   <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (bus.load) begin
        r_stg_data <= bus.data_in;
        r_stg_dp   <= bus.dp_in;
        r_stg_en   <= bus.en_in;
      end
      // A load on the wrap cycle stays pending for the next frame.
      r_pending <= bus.load | (r_pending & ~w_wrap);
    end
  end

  // Commit at frame boundary; the staged copy read here is the pre-load value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shd_data   <= '0;
      r_shd_dp     <= '0;
      r_shd_en     <= '0;
      r_upd_ack    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_shd_data <= r_stg_data;
        r_shd_dp   <= r_stg_dp;
        r_shd_en   <= r_stg_en;
      end
      r_upd_ack    <= w_wrap & r_pending;
      r_frame_done <= w_wrap;
    end
  end

  // Registered pin drive: a single anode at most, blanked digits fully dark.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_on  ? ~(8'b1 << r_idx) : AN_OFF;
      r_seg <= w_dig_en ? {~r_shd_dp[r_idx], w_seg7} : SEG_BLANK;
    end
  end

  assign bus.upd_ack    = r_upd_ack;
  assign bus.frame_done = r_frame_done;
  assign seg            = r_seg;
  assign an             = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed vector table for the scan driver at PRESCALE=4
// (32-clock frame), plus hand sequences for async reset mid-frame.
module tb_seg7_scan_driver;

  logic       CLK;
  logic       RST_N;
  logic [7:0] seg;
  logic [7:0] an;
`ifdef SEG7_BRIGHTNESS_EN
  logic [2:0] brightness = 3'd7;
`endif

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.PRESCALE(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
`ifdef SEG7_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .bus        (bus),
    .seg        (seg),
    .an         (an)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        ack;
    logic        fd;
  } vec_t;

  vec_t vq[$];
  int   cyc;
  int   ack_cnt;
  int   n_vec;
  int   n_err;

  task automatic add(input int c, input logic ld, input logic [31:0] d,
                     input logic [7:0] dp, input logic [7:0] en,
                     input logic [7:0] e_an, input logic [7:0] e_seg,
                     input logic e_ack, input logic e_fd);
    vec_t v;
    v.cyc = c; v.ld = ld; v.data = d; v.dp = dp; v.en = en;
    v.an = e_an; v.seg = e_seg; v.ack = e_ack; v.fd = e_fd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, c, act, exp);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (bus.upd_ack === 1'b1) ack_cnt++;
  endtask

  logic [7:0] seg_a [8];

  initial begin
    RST_N = 1'b0;
    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.en_in = '0;
    cyc = 0; ack_cnt = 0; n_vec = 0; n_err = 0;

    // Frame 1: 76543210, all enabled, dp on digit 0.
    seg_a = '{8'h40, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    add(1,  1, 32'h76543210, 8'h01, 8'hFF, 8'hFF, 8'hFF, 0, 0);
    add(31, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
    add(32, 0, 0, 0, 0, 8'hFF, 8'hFF, 1, 1);
    for (int d = 0; d < 8; d++) begin
      add(33 + 4*d, 0, 0, 0, 0, ~(8'(1) << d), seg_a[d], 0, 0);
      add(36 + 4*d, 0, 0, 0, 0, ~(8'(1) << d), seg_a[d], 0, (d == 7));
    end
    // Upper four digits blanked.
    add(65,  1, 32'h76543210, 8'h00, 8'h0F, 8'hFE, 8'h40, 0, 0);
    add(96,  0, 0, 0, 0, 8'h7F, 8'hF8, 1, 1);
    add(97,  0, 0, 0, 0, 8'hFE, 8'hC0, 0, 0);
    add(101, 0, 0, 0, 0, 8'hFD, 8'hF9, 0, 0);
    add(109, 0, 0, 0, 0, 8'hF7, 8'hB0, 0, 0);
    add(113, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
    add(127, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
    add(128, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 1);
    // Two loads in one frame: only the second is shown.
    add(130, 1, 32'h11111111, 8'h00, 8'hFF, 8'hFE, 8'hC0, 0, 0);
    add(140, 1, 32'h89ABCDEF, 8'h80, 8'hFF, 8'hFB, 8'hA4, 0, 0);
    add(160, 0, 0, 0, 0, 8'hFF, 8'hFF, 1, 1);
    add(161, 0, 0, 0, 0, 8'hFE, 8'h8E, 0, 0);
    add(165, 0, 0, 0, 0, 8'hFD, 8'h86, 0, 0);
    // Load C mid-frame, then load D on the exact wrap edge.
    add(180, 1, 32'hCCCCCCCC, 8'h00, 8'hFF, 8'hEF, 8'h83, 0, 0);
    add(189, 0, 0, 0, 0, 8'h7F, 8'h00, 0, 0);
    add(192, 1, 32'hDDDDDDDD, 8'h00, 8'hFF, 8'h7F, 8'h00, 1, 1);
    add(193, 0, 0, 0, 0, 8'hFE, 8'hC6, 0, 0);
    add(223, 0, 0, 0, 0, 8'h7F, 8'hC6, 0, 0);
    add(224, 0, 0, 0, 0, 8'h7F, 8'hC6, 1, 1);
    add(225, 0, 0, 0, 0, 8'hFE, 8'hA1, 0, 0);

    // Reset held.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_an",  0, an,  8'hFF);
    chk("rst_seg", 0, seg, 8'hFF);
    chk("rst_ack", 0, bus.upd_ack, 0);
    chk("rst_fd",  0, bus.frame_done, 0);
    RST_N = 1'b1;

    foreach (vq[i]) begin
      while (cyc < vq[i].cyc - 1) tick();
      if (vq[i].ld) begin
        bus.load = 1'b1; bus.data_in = vq[i].data;
        bus.dp_in = vq[i].dp; bus.en_in = vq[i].en;
      end
      tick();
      bus.load = 1'b0;
      chk("an",  cyc, an,  vq[i].an);
      chk("seg", cyc, seg, vq[i].seg);
      chk("upd_ack", cyc, bus.upd_ack, vq[i].ack);
      chk("frame_done", cyc, bus.frame_done, vq[i].fd);
    end
    chk("ack_total", cyc, ack_cnt, 5);

    // Pending update then async reset mid-frame: discarded, display stays dark.
    while (cyc < 227) tick();
    bus.load = 1'b1; bus.data_in = 32'h12345678;
    bus.dp_in = 8'hFF; bus.en_in = 8'hFF;
    tick();
    bus.load = 1'b0;
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_an",  cyc, an,  8'hFF);
    chk("mid_rst_seg", cyc, seg, 8'hFF);
    chk("mid_rst_ack", cyc, bus.upd_ack, 0);
    chk("mid_rst_fd",  cyc, bus.frame_done, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc = 0; ack_cnt = 0;
    while (cyc < 70) begin
      tick();
      if (an !== 8'hFF || seg !== 8'hFF)
        chk("post_rst_dark", cyc, {an, seg}, 16'hFFFF);
      if (cyc == 32) chk("post_rst_fd", cyc, bus.frame_done, 1);
    end
    chk("post_rst_dark_all", cyc, {an, seg}, 16'hFFFF);
    chk("post_rst_no_ack", cyc, ack_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
